// File: rtl/mem_arbiter.sv
// Round-robin arbiter in front of one single-port RAM.
// Grants one requester per cycle and returns read data one cycle after the grant.
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 4096,
    parameter int NUM_PORTS  = 2
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            req_valid,
    input  logic [NUM_PORTS-1:0]            req_we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]            req_ready,
    output logic [NUM_PORTS-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]           resp_rdata
);
    // Handshake: a transfer completes on the rising edge where req_valid[i] and
    // req_ready[i] are both 1; the requester holds we/addr/wdata stable until then.

    localparam int PW = (NUM_PORTS > 2) ? 2 : 1;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [PW:0]         NP_W    = (PW+1)'(NUM_PORTS);
    localparam logic [PW-1:0]       LAST    = PW'(NUM_PORTS-1);

    logic [PW-1:0]         ptr;
    logic [PW-1:0]         gidx;
    logic [PW:0]           slot;
    logic                  gnt_any;
    logic [NUM_PORTS-1:0]  grant;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_we;
    logic                  in_range;
    logic [IW-1:0]         ram_idx;
    logic [DATA_WIDTH-1:0] ram [DEPTH];

    // Search ports starting at the priority pointer, wrapping around once.
    always_comb begin
        grant   = '0;
        gidx    = '0;
        gnt_any = 1'b0;
        slot    = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            slot = {1'b0, ptr} + (PW+1)'(k);
            if (slot >= NP_W) slot = slot - NP_W;
            if (!gnt_any && req_valid[slot[PW-1:0]]) begin
                gnt_any = 1'b1;
                gidx    = slot[PW-1:0];
            end
        end
        if (!reset) gnt_any = 1'b0;
        if (gnt_any) grant[gidx] = 1'b1;
    end

    assign req_ready = grant;

    assign sel_addr  = req_addr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_wdata = req_wdata[gidx*DATA_WIDTH +: DATA_WIDTH];
    assign sel_we    = req_we[gidx];
    assign in_range  = ({1'b0, sel_addr} < DEPTH_W);
    assign ram_idx   = sel_addr[IW-1:0];

    // RAM has no reset so its contents survive reset assertion.
    always_ff @(posedge clock) begin
        if (gnt_any && sel_we && in_range) ram[ram_idx] <= sel_wdata;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr        <= '0;
            resp_valid <= '0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= grant & ~req_we;
            if (gnt_any) begin
                ptr <= (gidx == LAST) ? '0 : gidx + 1'b1;
                if (!sel_we) resp_rdata <= in_range ? ram[ram_idx] : '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a rule-level model
// of round-robin arbitration and a sparse memory image.
module tb_mem_arbiter;
    localparam int DW    = 32;
    localparam int AW    = 13;
    localparam int DEPTH = 4096;
    localparam int NP    = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [NP-1:0]     req_valid = '0;
    logic [NP-1:0]     req_we = '0;
    logic [NP*AW-1:0]  req_addr = '0;
    logic [NP*DW-1:0]  req_wdata = '0;
    logic [NP-1:0]     req_ready;
    logic [NP-1:0]     resp_valid;
    logic [DW-1:0]     resp_rdata;

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .NUM_PORTS(NP)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata)
    );

    always #5 clock = ~clock;

    int            tests = 0;
    int            fails = 0;
    int            mp;
    logic [DW-1:0] mmem [int];
    logic [NP-1:0] exp_g;
    logic [NP-1:0] exp_rv;
    logic [NP-1:0] last_ready;
    logic [DW-1:0] exp_rd;
    bit            exp_known;
    int            wait_cnt [NP];
    logic [NP-1:0] alt_tbl [4];
    logic [NP-1:0] p13_tbl [3];

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // First requesting port in the order p, p+1, ... wrapping to 0.
    function automatic logic [NP-1:0] model_grant();
        logic [NP-1:0] g;
        g = '0;
        if (!reset) return g;
        for (int k = 0; k < NP; k++) begin
            int i;
            i = (mp + k) % NP;
            if (req_valid[i]) begin
                g[i] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    task automatic set_req(input int i, input logic v, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]           = v;
        req_we[i]              = we;
        req_addr[i*AW +: AW]   = a;
        req_wdata[i*DW +: DW]  = d;
    endtask

    // One clock cycle: check grant, apply the model at the edge, check response.
    task automatic cycle();
        int a;
        #1;
        exp_g      = model_grant();
        last_ready = req_ready;
        chk("req_ready", 32'(req_ready), 32'(exp_g));
        @(posedge clock);
        exp_rv    = '0;
        exp_known = 1'b0;
        for (int i = 0; i < NP; i++) begin
            if (exp_g[i]) begin
                a = int'(req_addr[i*AW +: AW]);
                if (req_we[i]) begin
                    if (a < DEPTH) mmem[a] = req_wdata[i*DW +: DW];
                end else begin
                    exp_rv[i] = 1'b1;
                    if (a >= DEPTH) begin
                        exp_rd    = '0;
                        exp_known = 1'b1;
                    end else if (mmem.exists(a)) begin
                        exp_rd    = mmem[a];
                        exp_known = 1'b1;
                    end
                end
                mp = (i + 1) % NP;
            end
        end
        @(negedge clock);
        chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
        if (exp_known) chk("resp_rdata", resp_rdata, exp_rd);
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        req_valid = '1;
        mp        = 0;
        exp_rv    = '0;
        #1;
        chk("rst_ready", 32'(req_ready), 32'(model_grant()));
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        @(posedge clock);
        @(negedge clock);
        chk("rst_ready_edge", 32'(req_ready), 32'h0);
        chk("rst_resp_valid_edge", 32'(resp_valid), 32'h0);
        req_valid = '0;
        reset     = 1'b1;
    endtask

    initial begin
        alt_tbl = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
        p13_tbl = '{4'b1000, 4'b0010, 4'b1000};
        @(negedge clock);
        do_reset();

        // write then read-after-write on port 0
        set_req(0, 1'b1, 1'b1, 13'h010, 32'hDEADBEEF);
        cycle();
        chk("wr_first_grant", 32'(last_ready), 32'h1);
        set_req(0, 1'b1, 1'b0, 13'h010, 32'h0);
        cycle();
        chk("raw_valid", 32'(resp_valid), 32'h1);
        chk("raw_data", resp_rdata, 32'hDEADBEEF);
        req_valid = '0;
        cycle();

        // two ports holding reads alternate from port 0
        do_reset();
        set_req(0, 1'b1, 1'b0, 13'h001, 32'h0);
        set_req(1, 1'b1, 1'b0, 13'h002, 32'h0);
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("alt_grant", 32'(last_ready), 32'(alt_tbl[k]));
        end
        req_valid = '0;
        cycle();

        // pointer at 2 with ports 1 and 3 held
        do_reset();
        set_req(1, 1'b1, 1'b0, 13'h003, 32'h0);
        cycle();
        set_req(3, 1'b1, 1'b0, 13'h004, 32'h0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("p13_grant", 32'(last_ready), 32'(p13_tbl[k]));
        end
        req_valid = '0;
        cycle();

        // out-of-range write ignored, out-of-range read returns zero
        set_req(2, 1'b1, 1'b1, 13'h0000, 32'hA5A50000);
        cycle();
        set_req(2, 1'b1, 1'b1, 13'd4096, 32'h12345678);
        cycle();
        set_req(2, 1'b1, 1'b0, 13'd4096, 32'h0);
        cycle();
        chk("oor_valid", 32'(resp_valid), 32'h4);
        chk("oor_data", resp_rdata, 32'h0);
        set_req(2, 1'b1, 1'b0, 13'h0000, 32'h0);
        cycle();
        chk("addr0_data", resp_rdata, 32'hA5A50000);
        req_valid = '0;
        cycle();

        // reset right after a read grant drops the response, RAM survives
        set_req(0, 1'b1, 1'b1, 13'h020, 32'h0BADF00D);
        cycle();
        set_req(0, 1'b1, 1'b0, 13'h020, 32'h0);
        #1;
        chk("pre_rst_grant", 32'(req_ready), 32'h1);
        @(posedge clock);
        #1;
        reset     = 1'b0;
        req_valid = '0;
        mp        = 0;
        exp_rv    = '0;
        @(negedge clock);
        chk("drop_valid", 32'(resp_valid), 32'h0);
        chk("drop_rdata", resp_rdata, 32'h0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        cycle();
        chk("drop_after_release", 32'(resp_valid), 32'h0);
        set_req(0, 1'b1, 1'b0, 13'h020, 32'h0);
        cycle();
        chk("retain_data", resp_rdata, 32'h0BADF00D);
        req_valid = '0;

        // port 1 alone issues three back-to-back reads
        for (int k = 1; k <= 3; k++) begin
            set_req(3, 1'b1, 1'b1, 13'(k), 32'h11110000 + 32'(k));
            cycle();
        end
        req_valid = '0;
        for (int k = 1; k <= 3; k++) begin
            set_req(1, 1'b1, 1'b0, 13'(k), 32'h0);
            cycle();
            chk("seq_grant", 32'(last_ready), 32'h2);
            chk("seq_valid", 32'(resp_valid), 32'h2);
            chk("seq_data", resp_rdata, 32'h11110000 + 32'(k));
        end
        req_valid = '0;
        cycle();

        // randomized traffic with occasional withdrawn requests
        for (int i = 0; i < NP; i++) wait_cnt[i] = 0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NP; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        logic [AW-1:0] a;
                        if ($urandom_range(0, 9) < 8) a = AW'($urandom_range(0, 15));
                        else a = AW'($urandom_range(4090, 8191));
                        set_req(i, 1'b1, 1'($urandom_range(0, 1)), a, $urandom);
                        wait_cnt[i] = 0;
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            cycle();
            for (int i = 0; i < NP; i++) begin
                if (exp_g[i]) begin
                    chk("no_starve", 32'(wait_cnt[i] < NP), 32'h1);
                    req_valid[i] = 1'b0;
                end else if (req_valid[i]) begin
                    wait_cnt[i]++;
                end
            end
        end
        req_valid = '0;
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
